// File: rtl/lux_ascii_formatter.sv
// lux_ascii_formatter: turns a 16-bit unsigned light reading into five ASCII
// decimal digits for the LCD's second line.
//
// The binary-to-BCD conversion is shift-add-3, one bit per clock. The
// o_tick output pulses for one cycle when new digits are ready.
//
// With the optional macro LUX_FORMATTER_SCALE_EN defined, i_data is treated
// as a raw BH1750 count. It is first scaled to lux as floor(raw*5/6) by a
// 19-step restoring divider, and the conversion runs on the quotient.
module lux_ascii_formatter #(
  parameter int P_BLANK_LEADING = 0,
  parameter int P_WIDTH         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic [7:0]         o_byte4,
  output logic [7:0]         o_byte3,
  output logic [7:0]         o_byte2,
  output logic [7:0]         o_byte1,
  output logic [7:0]         o_byte0,
  output logic               o_tick,
  output logic               o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef LUX_FORMATTER_SCALE_EN
  localparam logic [1:0] S_SCALE  = 2'd1;
`endif
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FORMAT = 2'd3;

  localparam logic [7:0] C_LEAD = (P_BLANK_LEADING != 0) ? 8'h20 : 8'h30;

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic [P_WIDTH-1:0] bin;
  logic [19:0]        bcd;
  logic [19:0]        bcd_adj;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Map the BCD digits to ASCII. Leading zeros are blanked from the top
  // digit down when enabled. The ones digit is always a numeral.
  function automatic logic [39:0] to_ascii(input logic [19:0] b);
    logic [39:0] r;
    logic        lead;
    r    = '0;
    lead = (P_BLANK_LEADING != 0);
    for (int i = 4; i >= 1; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) begin
        r[8*i +: 8] = 8'h20;
      end else begin
        lead        = 1'b0;
        r[8*i +: 8] = {4'h3, b[4*i +: 4]};
      end
    end
    r[7:0] = {4'h3, b[3:0]};
    return r;
  endfunction

`ifdef LUX_FORMATTER_SCALE_EN
  logic [18:0] num;
  logic [2:0]  rem;
  logic [3:0]  div_trial;
  logic        div_ge;
  logic [2:0]  div_rem_next;
  logic [18:0] div_num_next;

  // One restoring-division step. The quotient bits shift into num as the
  // numerator bits shift out, so num holds the quotient after 19 steps.
  always_comb begin
    div_trial    = {rem, num[18]};
    div_ge       = (div_trial >= 4'd6);
    div_rem_next = div_ge ? 3'(div_trial - 4'd6) : div_trial[2:0];
    div_num_next = {num[17:0], div_ge};
  end
`endif

  // Pre-compute the add-3 correction for the current shift step.
  always_comb begin
    bcd_adj = bcd_adjust(bcd);
  end

  // Conversion sequencer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bin     <= '0;
      bcd     <= '0;
      o_byte4 <= C_LEAD;
      o_byte3 <= C_LEAD;
      o_byte2 <= C_LEAD;
      o_byte1 <= C_LEAD;
      o_byte0 <= 8'h30;
      o_tick  <= 1'b0;
      o_busy  <= 1'b0;
`ifdef LUX_FORMATTER_SCALE_EN
      num     <= '0;
      rem     <= '0;
`endif
    end else begin
      o_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            bcd    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
`ifdef LUX_FORMATTER_SCALE_EN
            num    <= ({3'b000, i_data} << 2) + {3'b000, i_data};
            rem    <= '0;
            state  <= S_SCALE;
`else
            bin    <= i_data;
            state  <= S_SHIFT;
`endif
          end
        end
`ifdef LUX_FORMATTER_SCALE_EN
        S_SCALE: begin
          num <= div_num_next;
          rem <= div_rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd18) begin
            bin   <= div_num_next[P_WIDTH-1:0];
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
`endif
        S_SHIFT: begin
          bcd <= {bcd_adj[18:0], bin[P_WIDTH-1]};
          bin <= bin << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd15) state <= S_FORMAT;
        end
        S_FORMAT: begin
          {o_byte4, o_byte3, o_byte2, o_byte1, o_byte0} <= to_ascii(bcd);
          o_tick <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
